// File: rtl/dm_bus_arbiter.sv
// Two-master system-bus arbiter: CPU load/store unit versus debug-module bus access.
// Optional response-phase timeout is compiled in with `define DM_BUS_TIMEOUT_EN.
module dm_bus_arbiter #(
  parameter int unsigned MAX_WAIT       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sel_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_sel_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        dm_owner_o,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("dm_bus_arbiter: MAX_WAIT must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dm_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t      state, state_next;
  logic        owner, owner_next;
  logic [7:0]  wait_cnt, wait_next;
  logic        owner_req, owner_we;
  logic [31:0] owner_addr, owner_wdata;
  logic [3:0]  owner_sel;
  logic        dm_wins, cpu_waiting;
  logic        gnt, rvalid, timeout;
  logic [31:0] rdata;

`ifdef DM_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;
`endif

  // owner: 0 = CPU, 1 = DM; the non-owner's request fields never reach the bus.
  assign owner_req   = owner ? dm_req_i   : cpu_req_i;
  assign owner_we    = owner ? dm_we_i    : cpu_we_i;
  assign owner_addr  = owner ? dm_addr_i  : cpu_addr_i;
  assign owner_wdata = owner ? dm_wdata_i : cpu_wdata_i;
  assign owner_sel   = owner ? dm_sel_i   : cpu_sel_i;

  assign dm_wins     = dm_req_i && !(cpu_req_i && (wait_cnt >= MAX_WAIT_CNT));
  assign cpu_waiting = cpu_req_i && ((state == IDLE) ? dm_wins : owner);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      wait_cnt <= wait_next;
    end
  end

  // Outputs are forced low while rst_n is low so an aborted transfer leaks nothing.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_sel_o   = '0;
    gnt         = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
    timeout     = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (cpu_req_i || dm_req_i) begin
            owner_next = dm_wins;
            state_next = ADDR;
          end
        end
        ADDR: begin
          if (!owner_req) begin
            state_next = IDLE;
          end else begin
            bus_req_o   = 1'b1;
            bus_we_o    = owner_we;
            bus_addr_o  = owner_addr;
            bus_wdata_o = owner_wdata;
            bus_sel_o   = owner_sel;
            if (bus_gnt_i) begin
              gnt = 1'b1;
              if (bus_rvalid_i) begin
                rvalid     = 1'b1;
                rdata      = bus_rdata_i;
                state_next = IDLE;
              end else begin
                state_next = DATA;
              end
            end
          end
        end
        DATA: begin
          if (bus_rvalid_i) begin
            rvalid     = 1'b1;
            rdata      = bus_rdata_i;
            state_next = IDLE;
          end
`ifdef DM_BUS_TIMEOUT_EN
          else if (tmo_cnt >= TIMEOUT_CNT) begin
            rvalid     = 1'b1;
            timeout    = 1'b1;
            state_next = IDLE;
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    wait_next = wait_cnt;
    if (cpu_gnt_o) begin
      wait_next = '0;
    end else if (cpu_waiting && (wait_cnt != 8'hFF)) begin
      wait_next = wait_cnt + 8'd1;
    end
  end

`ifdef DM_BUS_TIMEOUT_EN
  // Held at zero outside DATA, so it restarts on every entry to the response phase.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != DATA)) begin
      tmo_cnt <= '0;
    end else if (!bus_rvalid_i && (tmo_cnt != TIMEOUT_CNT)) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`endif

  assign cpu_gnt_o     = gnt & ~owner;
  assign dm_gnt_o      = gnt & owner;
  assign cpu_rvalid_o  = rvalid & ~owner;
  assign dm_rvalid_o   = rvalid & owner;
  assign cpu_rdata_o   = owner ? 32'h0 : rdata;
  assign dm_rdata_o    = owner ? rdata : 32'h0;
  assign dm_owner_o    = rst_n && (state != IDLE) && owner;
  assign timeout_err_o = timeout;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: vector table plus hand sequences, responses via scoreboard queue.
`timescale 1ns/1ps
module tb_dm_bus_arbiter;

  localparam int MAX_WAIT       = 8;
  localparam int TIMEOUT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_gnt_o, cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        dm_req_i, dm_we_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic [3:0]  dm_sel_i;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        dm_owner_o, timeout_err_o;

  always #5 clk = ~clk;

  dm_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_sel_i(cpu_sel_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .dm_owner_o(dm_owner_o), .timeout_err_o(timeout_err_o)
  );

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t  exp_q[$];
  rsp_t  mon_exp;
  vec_t  vecs[6];
  int    tests = 0;
  int    failed = 0;
  int    cpu_gnt_cnt = 0, dm_gnt_cnt = 0;
  int    exp_cpu_gnt = 0, exp_dm_gnt = 0;
  string cur_tag = "reset";

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic push_exp(input logic dm, input logic [31:0] rd);
    rsp_t e;
    e.dm    = dm;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic dm, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    if (dm) begin
      dm_req_i = req; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata; dm_sel_i = sel;
    end else begin
      cpu_req_i = req; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_sel_i = sel;
    end
  endtask

  task automatic check_quiet_outputs(input string name);
    check_output({name, "_ctrl"}, {24'b0, bus_req_o, bus_we_o, cpu_gnt_o, cpu_rvalid_o,
                                  dm_gnt_o, dm_rvalid_o, dm_owner_o, timeout_err_o}, 32'h0);
    check_output({name, "_bus_addr"}, bus_addr_o, 32'h0);
    check_output({name, "_bus_wdata"}, bus_wdata_o, 32'h0);
    check_output({name, "_bus_sel"}, {28'b0, bus_sel_o}, 32'h0);
    check_output({name, "_cpu_rdata"}, cpu_rdata_o, 32'h0);
    check_output({name, "_dm_rdata"}, dm_rdata_o, 32'h0);
  endtask

  // Response scoreboard: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_gnt_o) cpu_gnt_cnt++;
    if (dm_gnt_o) dm_gnt_cnt++;
    if (cpu_rvalid_o || dm_rvalid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL %s.unexpected_rvalid: got cpu=%0b dm=%0b, expected none",
                 cur_tag, cpu_rvalid_o, dm_rvalid_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check_bit("rsp_cpu_rvalid", cpu_rvalid_o, !mon_exp.dm);
        check_bit("rsp_dm_rvalid", dm_rvalid_o, mon_exp.dm);
        check_output("rsp_rdata", mon_exp.dm ? dm_rdata_o : cpu_rdata_o, mon_exp.rdata);
        check_output("rsp_other_rdata", mon_exp.dm ? cpu_rdata_o : dm_rdata_o, 32'h0);
      end
    end
`ifndef DM_BUS_TIMEOUT_EN
    check_bit("timeout_err_tied", timeout_err_o, 1'b0);
`endif
  end

  // One complete transaction from an idle arbiter, with the slave timing taken from the vector.
  task automatic apply_stimulus(input vec_t v);
    @(posedge clk); #1;
    drive_req(v.dm, 1'b1, v.we, v.addr, v.wdata, v.sel);
    @(negedge clk);
    check_bit("idle_no_bus_req", bus_req_o, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < v.gnt_dly; k++) begin
      @(negedge clk);
      check_bit("addr_bus_req", bus_req_o, 1'b1);
      @(posedge clk); #1;
    end
    bus_gnt_i = 1'b1;
    if (v.rsp_dly == 0) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = v.rdata;
      push_exp(v.dm, v.rdata);
    end
    @(negedge clk);
    check_output("gnt_pair", {30'b0, cpu_gnt_o, dm_gnt_o}, v.dm ? 32'd1 : 32'd2);
    check_bit("dm_owner", dm_owner_o, v.dm);
    check_bit("bus_req", bus_req_o, 1'b1);
    check_bit("bus_we", bus_we_o, v.we);
    check_output("bus_addr", bus_addr_o, v.addr);
    check_output("bus_wdata", bus_wdata_o, v.wdata);
    check_output("bus_sel", {28'b0, bus_sel_o}, {28'b0, v.sel});
    if (v.dm) exp_dm_gnt++; else exp_cpu_gnt++;
    @(posedge clk); #1;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    drive_req(v.dm, 1'b0, v.we, v.addr, v.wdata, v.sel);
    if (v.rsp_dly > 0) begin
      for (int k = 1; k < v.rsp_dly; k++) begin
        @(negedge clk);
        check_bit("data_no_bus_req", bus_req_o, 1'b0);
        check_bit("data_dm_owner", dm_owner_o, v.dm);
        @(posedge clk); #1;
      end
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = v.rdata;
      push_exp(v.dm, v.rdata);
      @(negedge clk);
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'h0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 100us");
    failed++;
    tests++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dm_run;
    int cpu_rounds;
    int fire_at;
    logic rsp_pending;
    logic rsp_dm;
    logic [31:0] rd;

    vecs[0] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 2, 3, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 4'hF, 0, 1, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 1, 2, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0000_0000, 4'hF, 0, 0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0020, 32'h0000_0000, 4'hC, 0, 0, 32'h0BAD_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h1000_0100, 32'h0000_0000, 4'h1, 3, 1, 32'h55AA_33CC};

    rst_n = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0; cpu_sel_i = 4'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_sel_i = 4'h0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i]);
    end

    // Simultaneous requests: DM first, then the CPU, then a zero-latency back-to-back CPU access.
    cur_tag = "both";
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 4'hF);
    drive_req(1'b0, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    check_output("dm_first_gnt", {30'b0, cpu_gnt_o, dm_gnt_o}, 32'd1);
    check_bit("dm_owner", dm_owner_o, 1'b1);
    check_bit("dm_bus_we", bus_we_o, 1'b1);
    check_output("dm_bus_wdata", bus_wdata_o, 32'hA5A5_A5A5);
    check_output("dm_bus_addr", bus_addr_o, 32'h2000_0000);
    exp_dm_gnt++;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    dm_req_i  = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h0;
    push_exp(1'b1, 32'h0);
    @(negedge clk);
    check_bit("dm_owner_data", dm_owner_o, 1'b1);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check_bit("idle_between", bus_req_o, 1'b0);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'h7777_0001;
    push_exp(1'b0, 32'h7777_0001);
    @(negedge clk);
    check_output("cpu_zero_lat_gnt", {30'b0, cpu_gnt_o, dm_gnt_o}, 32'd2);
    check_bit("cpu_not_dm_owner", dm_owner_o, 1'b0);
    check_output("cpu_bus_addr", bus_addr_o, 32'h8000_0040);
    exp_cpu_gnt++;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    cpu_addr_i = 32'h8000_0044;
    @(negedge clk);
    check_bit("zero_lat_back_to_idle", bus_req_o, 1'b0);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_0002;
    push_exp(1'b0, 32'h7777_0002);
    @(negedge clk);
    check_bit("next_req_accepted", bus_req_o, 1'b1);
    check_output("next_req_addr", bus_addr_o, 32'h8000_0044);
    check_bit("next_req_gnt", cpu_gnt_o, 1'b1);
    exp_cpu_gnt++;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    cpu_req_i = 1'b0;

    // Owner withdraws before the slave grants: request drops at once, no grant.
    cur_tag = "withdraw";
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("bus_req_before_drop", bus_req_o, 1'b1);
    @(posedge clk); #1;
    dm_req_i = 1'b0;
    @(negedge clk);
    check_bit("bus_req_after_drop", bus_req_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("back_to_idle", dm_owner_o, 1'b0);

    // Continuous DM traffic with a waiting CPU: three DM grants, then the CPU, twice.
    cur_tag = "starve";
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'hF);
    drive_req(1'b1, 1'b1, 1'b0, 32'h2000_1000, 32'h0, 4'hF);
    dm_run = 0;
    cpu_rounds = 0;
    rsp_pending = 1'b0;
    rsp_dm = 1'b0;
    for (int cyc = 0; cyc < 60 && cpu_rounds < 2; cyc++) begin
      rd = 32'h5A00_0000 + 32'(cyc);
      bus_rvalid_i = rsp_pending;
      bus_rdata_i  = rsp_pending ? rd : 32'h0;
      if (rsp_pending) push_exp(rsp_dm, rd);
      bus_gnt_i = 1'b0;
      #1 bus_gnt_i = bus_req_o;
      @(negedge clk);
      rsp_pending = 1'b0;
      if (dm_gnt_o) begin
        dm_run++;
        exp_dm_gnt++;
        rsp_pending = 1'b1;
        rsp_dm = 1'b1;
      end
      if (cpu_gnt_o) begin
        check_output("dm_grants_before_cpu", 32'(dm_run), 32'd3);
        dm_run = 0;
        cpu_rounds++;
        exp_cpu_gnt++;
        rsp_pending = 1'b1;
        rsp_dm = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_output("cpu_rounds", 32'(cpu_rounds), 32'd2);
    bus_gnt_i = 1'b0;
    cpu_req_i = 1'b0;
    dm_req_i  = 1'b0;
    bus_rvalid_i = rsp_pending;
    bus_rdata_i  = 32'h5A00_FFFF;
    if (rsp_pending) push_exp(rsp_dm, 32'h5A00_FFFF);
    @(negedge clk);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;

    // Reset while waiting for a response; a late response must be dropped.
    cur_tag = "reset_mid";
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    check_bit("gnt", cpu_gnt_o, 1'b1);
    exp_cpu_gnt++;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBAD0_0001;
    @(negedge clk);
    check_quiet_outputs("in_reset");
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    @(negedge clk);
    check_quiet_outputs("in_reset2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBAD0_0002;
    @(negedge clk);
    check_bit("late_cpu_rvalid", cpu_rvalid_o, 1'b0);
    check_bit("late_dm_rvalid", dm_rvalid_o, 1'b0);
    check_output("late_cpu_rdata", cpu_rdata_o, 32'h0);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    cur_tag = "after_reset";
    apply_stimulus(vecs[0]);

    // Slave that never answers.
    cur_tag = "timeout";
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    check_bit("gnt", cpu_gnt_o, 1'b1);
    exp_cpu_gnt++;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    cpu_req_i = 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
    push_exp(1'b0, 32'h0);
    fire_at = -1;
    for (int c = 1; c <= 20 && fire_at < 0; c++) begin
      @(negedge clk);
      if (cpu_rvalid_o) begin
        fire_at = c;
        check_bit("err_with_rvalid", timeout_err_o, 1'b1);
      end else begin
        check_bit("err_quiet", timeout_err_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    check_output("fire_cycle", 32'(fire_at), 32'(TIMEOUT_CYCLES + 1));
    @(negedge clk);
    check_bit("err_single_pulse", timeout_err_o, 1'b0);
    check_bit("err_idle_bus_req", bus_req_o, 1'b0);
    fire_at = 0;
`else
    fire_at = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_bit("stall_no_rvalid", cpu_rvalid_o, 1'b0);
      check_bit("stall_no_bus_req", bus_req_o, 1'b0);
      @(posedge clk); #1;
    end
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h600D_0001;
    push_exp(1'b0, 32'h600D_0001);
    @(negedge clk);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
`endif

    cur_tag = "final";
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("pending_responses", 32'(exp_q.size()), 32'd0);
    check_output("cpu_gnt_pulses", 32'(cpu_gnt_cnt), 32'(exp_cpu_gnt));
    check_output("dm_gnt_pulses", 32'(dm_gnt_cnt), 32'(exp_dm_gnt));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single system-bus master port between the CPU load/store unit (M0) and the JTAG debug module system-bus access path (M1).
- Single outstanding transaction; the grant is locked from address phase through response phase.
- Debug has priority, with an anti-starvation counter guaranteeing the CPU forward progress.
- Sits between core LSU, jtag_dm memory outputs and the bus interconnect.

Parameters:
- MAX_WAIT, 8: CPU-wait cycles after which the CPU wins over a pending DM request; range 1..255.
- TIMEOUT_CYCLES, 64: response-phase timeout, used only with the optional feature; range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cpu_req_i  in  1  CPU request; held until cpu_gnt_o
- cpu_we_i  in  1  CPU write enable
- cpu_addr_i  in  32  CPU address
- cpu_wdata_i  in  32  CPU write data
- cpu_sel_i  in  4  CPU byte select
- cpu_gnt_o  out  1  address accepted (1-cycle pulse)
- cpu_rvalid_o  out  1  response valid (1-cycle pulse)
- cpu_rdata_o  out  32  response data
- dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_sel_i  in  1/1/32/32/4  DM request set, same semantics as CPU
- dm_gnt_o  out  1, dm_rvalid_o  out  1, dm_rdata_o  out  32  DM grant and response
- bus_req_o  out  1  bus request
- bus_we_o  out  1, bus_addr_o  out  32, bus_wdata_o  out  32, bus_sel_o  out  4  muxed from owner
- bus_gnt_i  in  1  slave accepted address
- bus_rvalid_i  in  1  slave response valid
- bus_rdata_i  in  32  slave read data
- dm_owner_o  out  1  1 while DM owns bus (ADDR/DATA states)
- timeout_err_o  out  1  timeout pulse; tied 0 without the optional feature

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n (sampled on the rising edge of clk only).
- Reset values:
  - state = IDLE, owner = CPU, wait counter = 0, timeout counter = 0.
  - All outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate on cpu_req_i and dm_req_i. The winner is registered as owner and the state moves to ADDR.
  - Priority: DM wins when both request, unless wait_cnt >= MAX_WAIT, in which case the CPU wins.
  - No request: remain in IDLE.
- ADDR:
  - bus_req_o = 1. bus_we/addr/wdata/sel are driven combinationally from the owner's inputs; the non-owner's fields are ignored.
  - On bus_gnt_i: pulse the owner's gnt for that same cycle, then go to DATA.
  - If bus_gnt_i and bus_rvalid_i arrive in the same cycle: pulse gnt and rvalid together, forward bus_rdata_i, and go to IDLE.
  - If the owner drops its req before grant: deassert bus_req_o in that same cycle and return to IDLE with no grant issued.
- DATA:
  - bus_req_o = 0.
  - On bus_rvalid_i: owner rvalid = 1 and rdata = bus_rdata_i (combinational pass-through), then go to IDLE.
  - Non-owner rvalid stays 0 and its rdata is 0.
  - New requests are not sampled in DATA.
- Request latency: minimum from request to bus_req_o is 1 cycle. Back-to-back transactions cost 1 IDLE cycle each.
- Wait counter (8-bit):
  - Increments each cycle cpu_req_i = 1 while the CPU is not the owner in ADDR/DATA, or loses in IDLE; saturates at 255.
  - Clears when the CPU receives cpu_gnt_o.
- dm_owner_o = (state != IDLE) and owner == DM.
- Reset mid-transaction: returns to IDLE immediately. No grant or response is delivered for the aborted transaction; late bus_rvalid_i in IDLE is ignored.
- A write transaction still waits for bus_rvalid_i (write acknowledge).

Optional Feature:
- Macro: DM_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to DATA and increments each DATA cycle without bus_rvalid_i.
  - On reaching TIMEOUT_CYCLES: owner rvalid pulses with rdata = 32'h0, timeout_err_o pulses 1 cycle, and the state returns to IDLE.
  - A bus_rvalid_i arriving in the same cycle wins: normal response, no error.
- Not defined:
  - DATA waits indefinitely and timeout_err_o = 0.
  - The port is always present.

Test Plan:
- CPU-only read to 0x8000_0010; slave gnt after 2 cycles, rvalid after 3 with 0x1234_5678 -> cpu_gnt_o single pulse; cpu_rvalid_o pulse with cpu_rdata_o = 0x1234_5678; dm_* outputs stay 0; bus_req_o asserted 1 cycle after cpu_req_i.
- CPU and DM both request in the same cycle, DM write 0xA5A5_A5A5 to 0x2000_0000 -> DM served first with bus_we_o = 1 and bus_wdata_o = 0xA5A5_A5A5; dm_owner_o = 1; CPU served next.
- DM requests continuously while the CPU requests, MAX_WAIT = 8 -> the CPU is granted no later than the arbitration following wait_cnt reaching 8; wait_cnt clears at cpu_gnt_o.
- Zero-latency slave (bus_gnt_i and bus_rvalid_i asserted in the same cycle) -> gnt and rvalid pulse in the same cycle; state returns to IDLE; next request accepted the following cycle.
- rst_n low while in DATA, then slave rvalid 2 cycles after reset release -> no rvalid to either master; all outputs 0 during reset.
- With DM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, slave never responds -> after 4 DATA cycles, owner rvalid = 1 with rdata 0 and timeout_err_o = 1 for one cycle. Without the macro: the bench observes a stall and timeout_err_o stays 0.
